ota_cmp_decimator: RTL and testbench

//  Downstream consumer of the digital OTA/comparator output pin (ua[2] net "Out").

---
 rtl/ota_cmp_decimator_if.sv | 36 +++
 rtl/ota_cmp_decimator.sv | 182 ++++++++++++++++++
 tb/tb_ota_cmp_decimator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ota_cmp_decimator_if.sv
`default_nettype none
// ============================================================================
// Module   : ota_cmp_decimator_if
// Purpose  : Control and result handshake bundle for the OTA comparator
//            decimator.
//            master : consumer side; drives start/cont/ack, reads the result
//            slave  : decimator side; reads start/cont/ack, drives the result
// Signals  : start      1  begin-conversion pulse
//            cont       1  re-arm the accumulate window after each result
//            ack        1  consumer accepts the current code
//            code       8  conversion result
//            code_valid 1  code holds an unacknowledged result
//            overrun    1  sticky: a result was overwritten before ack
//            busy       1  converter not idle
// Revision : 1.0  initial release
// ============================================================================
interface ota_cmp_decimator_if;
  logic       start;
  logic       cont;
  logic       ack;
  logic [7:0] code;
  logic       code_valid;
  logic       overrun;
  logic       busy;

  modport master (
    output start, cont, ack,
    input  code, code_valid, overrun, busy
  );

  modport slave (
    input  start, cont, ack,
    output code, code_valid, overrun, busy
  );
endinterface
`default_nettype wire

// File: rtl/ota_cmp_decimator.sv
`default_nettype none
// ============================================================================
// Module   : ota_cmp_decimator
// Purpose  : Synchronises the asynchronous comparator level, removes glitches
//            shorter than FILT_LEN clocks, and counts ones over a 2^WIN_LOG2
//            clock window to form an 8-bit pulse-density code delivered on a
//            valid/ack handshake.
// Ports    : clk     system clock
//            rst_n   asynchronous active-low reset
//            ena     design enable; low aborts a conversion in progress
//            cmp_in  raw comparator level, asynchronous to clk
//            bus     ota_cmp_decimator_if.slave (start/cont/ack in,
//                    code/code_valid/overrun/busy out)
// Params   : WIN_LOG2  log2 of the accumulate window in clocks (4..8)
//            FILT_LEN  consecutive samples to change filtered level (1..7)
// Revision : 1.0  initial release
// ============================================================================
module ota_cmp_decimator #(
  parameter int WIN_LOG2 = 8,
  parameter int FILT_LEN = 3
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           ena,
  input  wire logic           cmp_in,
  ota_cmp_decimator_if.slave  bus
);

  localparam int         c_ONES_W      = WIN_LOG2 + 1;
  localparam int         c_SHIFT       = 8 - WIN_LOG2;
  localparam logic [3:0] c_SETTLE_LAST = 4'(FILT_LEN + 1);
  localparam logic [2:0] c_RUN_LAST    = 3'(FILT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2
  } state_t;

  // Synchroniser and glitch filter
  logic                r_sync1;
  logic                r_sync2;
  logic                r_filt;
  logic [2:0]          r_run;

  // Conversion FSM
  state_t              r_state;
  logic                r_busy;
  logic [3:0]          r_settle_cnt;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [c_ONES_W-1:0] r_ones;
  logic [c_ONES_W-1:0] r_res;
  logic                r_done;

  // Result / handshake
  logic [7:0]          r_code;
  logic                r_code_valid;
  logic                r_overrun;

  logic [c_ONES_W-1:0] w_ones_next;
  logic                w_win_last;
  logic [8:0]          w_scaled;
  logic [7:0]          w_code;

  assign w_ones_next = r_ones + c_ONES_W'(r_filt);
  assign w_win_last  = (r_win_cnt == {WIN_LOG2{1'b1}});
  // Scale the ones count to the 8-bit range; a full window maps to 256,
  // which saturates to 0xFF.
  assign w_scaled    = 9'(r_res) << c_SHIFT;
  assign w_code      = w_scaled[8] ? 8'hFF : w_scaled[7:0];

  // Sync and filter run independently of ena and of the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_run   <= 3'd0;
    end else begin
      r_sync1 <= cmp_in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_filt) begin
        r_run <= 3'd0;
      end else if (r_run == c_RUN_LAST) begin
        r_filt <= r_sync2;
        r_run  <= 3'd0;
      end else begin
        r_run <= r_run + 3'd1;
      end
    end
  end

  // Window result is staged in r_res/r_done so the code register updates
  // one edge after the last accumulate clock, independent of whether the
  // FSM re-arms or returns to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_settle_cnt <= 4'd0;
      r_win_cnt    <= '0;
      r_ones       <= '0;
      r_res        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && ena) begin
            r_state      <= S_SETTLE;
            r_busy       <= 1'b1;
            r_settle_cnt <= 4'd0;
            r_win_cnt    <= '0;
            r_ones       <= '0;
          end
        end
        S_SETTLE: begin
          if (!ena) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_settle_cnt == c_SETTLE_LAST) begin
            r_state <= S_ACCUM;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        S_ACCUM: begin
          if (!ena) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_ones    <= '0;
            r_win_cnt <= '0;
          end else if (w_win_last) begin
            r_res     <= w_ones_next;
            r_done    <= 1'b1;
            r_ones    <= '0;
            r_win_cnt <= '0;
            if (!bus.cont) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_ones    <= w_ones_next;
            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // A new result always wins over a same-edge ack; overrun only sets when
  // an unacknowledged result is replaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_code       <= 8'h00;
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (r_done) begin
      r_code       <= w_code;
      r_code_valid <= 1'b1;
      if (r_code_valid && !bus.ack) begin
        r_overrun <= 1'b1;
      end else if (r_code_valid && bus.ack) begin
        r_overrun <= 1'b0;
      end
    end else if (r_code_valid && bus.ack) begin
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ota_cmp_decimator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ota_cmp_decimator
// Purpose  : Directed self-checking bench for ota_cmp_decimator. Two
//            instances: dut8 (WIN_LOG2=8) and dut4 (WIN_LOG2=4), FILT_LEN=3.
//            A pattern process drives each comparator input from a selectable
//            waveform (constant, square, glitch train, 4-of-16 pulse).
// Revision : 1.0  initial release
// ============================================================================
module tb_ota_cmp_decimator;

  logic clk;
  logic rst_n;
  logic ena;
  logic cmp8;
  logic cmp4;

  int n_vec;
  int n_err;

  // Pattern selection: 0 const, 1 square 4/4, 2 glitch train, 3 4-of-16
  int   mode8;
  int   mode4;
  logic lvl8;
  logic lvl4;
  int   ph;

  ota_cmp_decimator_if if8 ();
  ota_cmp_decimator_if if4 ();

  ota_cmp_decimator #(.WIN_LOG2(8), .FILT_LEN(3)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .cmp_in (cmp8),
    .bus    (if8)
  );

  ota_cmp_decimator #(.WIN_LOG2(4), .FILT_LEN(3)) dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .cmp_in (cmp4),
    .bus    (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic pat(input int mode, input int p, input logic lvl);
    case (mode)
      1:       return ((p % 8) < 4);
      2:       return ((p % 10) == 0) || ((p % 10) == 5) || ((p % 10) == 6);
      3:       return ((p % 16) < 4);
      default: return lvl;
    endcase
  endfunction

  initial begin
    ph   = 0;
    cmp8 = 1'b0;
    cmp4 = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cmp8 = pat(mode8, ph, lvl8);
      cmp4 = pat(mode4, ph, lvl4);
      ph   = ph + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the selected instance and count edges until code_valid.
  task automatic conv(input bit sel4, output int lat);
    if (sel4) if4.start = 1'b1; else if8.start = 1'b1;
    tick();
    if4.start = 1'b0;
    if8.start = 1'b0;
    lat = 0;
    while (!(sel4 ? if4.code_valid : if8.code_valid) && lat < 600) begin
      tick();
      lat = lat + 1;
    end
  endtask

  task automatic ack8();
    if8.ack = 1'b1;
    tick();
    if8.ack = 1'b0;
  endtask

  int lat;
  int n;

  initial begin
    n_vec = 0;
    n_err = 0;
    mode8 = 0;
    mode4 = 0;
    lvl8  = 1'b1;
    lvl4  = 1'b1;
    rst_n = 1'b0;
    ena   = 1'b1;
    if8.start = 1'b0; if8.cont = 1'b0; if8.ack = 1'b0;
    if4.start = 1'b0; if4.cont = 1'b0; if4.ack = 1'b0;
    ticks(3);

    // Reset state
    chk("rst_code",    32'(if8.code), 32'h00);
    chk("rst_valid",   32'(if8.code_valid), 32'd0);
    chk("rst_overrun", 32'(if8.overrun), 32'd0);
    chk("rst_busy",    32'(if8.busy), 32'd0);
    chk("rst_code4",   32'(if4.code), 32'h00);
    rst_n = 1'b1;
    ticks(10);

    // 1: constant high -> 0xFF, result on edge 262
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    chk("t1_busy_on", 32'(if8.busy), 32'd1);
    lat = 0;
    while (!if8.code_valid && lat < 600) begin
      tick();
      lat = lat + 1;
    end
    chk("t1_latency", 32'(lat), 32'd262);
    chk("t1_code",    32'(if8.code), 32'hFF);
    chk("t1_busy_off", 32'(if8.busy), 32'd0);
    ack8();
    chk("ack_valid",  32'(if8.code_valid), 32'd0);
    chk("ack_keep",   32'(if8.code), 32'hFF);

    // 2: 4-high/4-low square -> around mid-scale
    mode8 = 1;
    ticks(20);
    conv(1'b0, lat);
    chk("t2_in_range", 32'((if8.code >= 8'h7F) && (if8.code <= 8'h81)), 32'd1);
    ack8();

    // 3: low with 1- and 2-clock glitches -> all rejected
    mode8 = 2;
    ticks(20);
    conv(1'b0, lat);
    chk("t3_glitch_code", 32'(if8.code), 32'h00);
    ack8();

    // 6: 4-of-16 pulses give 0x40; ena drop mid-ACCUM keeps that result
    mode8 = 3;
    ticks(30);
    conv(1'b0, lat);
    chk("t6_code", 32'(if8.code), 32'h40);
    mode8 = 0;
    lvl8  = 1'b1;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    ticks(30);
    chk("t6_busy_mid", 32'(if8.busy), 32'd1);
    ena = 1'b0;
    tick();
    chk("t6_busy_off", 32'(if8.busy), 32'd0);
    chk("t6_code_kept", 32'(if8.code), 32'h40);
    chk("t6_valid_kept", 32'(if8.code_valid), 32'd1);
    ena = 1'b1;
    ticks(300);
    chk("t6_no_result", 32'(if8.code), 32'h40);
    chk("t6_still_valid", 32'(if8.code_valid), 32'd1);
    ack8();

    // 4: continuous mode, no ack across two windows -> overrun
    ticks(10);
    if8.cont = 1'b1;
    conv(1'b0, lat);
    chk("t4_latency", 32'(lat), 32'd262);
    chk("t4_code1",   32'(if8.code), 32'hFF);
    // Input falls now; sync+filter delay leaves 6 ones in window two.
    lvl8 = 1'b0;
    n = 0;
    while (!if8.overrun && n < 600) begin
      tick();
      n = n + 1;
    end
    chk("t4_win_len", 32'(n), 32'd256);
    chk("t4_code2",   32'(if8.code), 32'h06);
    chk("t4_valid",   32'(if8.code_valid), 32'd1);
    if8.cont = 1'b0;
    ack8();
    chk("t4_ack_valid",   32'(if8.code_valid), 32'd0);
    chk("t4_ack_overrun", 32'(if8.overrun), 32'd0);
    n = 0;
    while (!if8.code_valid && n < 600) begin
      tick();
      n = n + 1;
    end
    chk("t4_code3",    32'(if8.code), 32'h00);
    chk("t4_ovr3",     32'(if8.overrun), 32'd0);
    chk("t4_busy3",    32'(if8.busy), 32'd0);

    // 5: async reset between edges while accumulating
    lvl8 = 1'b1;
    ticks(10);
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    ticks(50);
    #3;
    rst_n = 1'b0;
    #2;
    chk("t5_valid", 32'(if8.code_valid), 32'd0);
    chk("t5_code",  32'(if8.code), 32'h00);
    chk("t5_busy",  32'(if8.busy), 32'd0);
    chk("t5_state", 32'(dut8.r_state), 32'd0);
    #2;
    rst_n = 1'b1;
    ticks(10);
    conv(1'b0, lat);
    chk("t5_latency", 32'(lat), 32'd262);
    chk("t5_code_ff", 32'(if8.code), 32'hFF);
    ack8();

    // 7: short window saturation and half-scale
    conv(1'b1, lat);
    chk("t7_latency", 32'(lat), 32'd22);
    chk("t7_sat",     32'(if4.code), 32'hFF);
    if4.ack = 1'b1;
    tick();
    if4.ack = 1'b0;
    mode4 = 1;
    ticks(20);
    conv(1'b1, lat);
    chk("t7_half",    32'(if4.code), 32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
